vote_button_conditioner: RTL

//  Front-end conditioning stage placed directly upstream of votingMachine.
//  - Synchronizes the four raw candidate buttons, debounces them, and rejects simultaneous presses.
//  - Emits exactly one registered, one-cycle, one-hot vote pulse per valid press.
//  - In result mode (mode=1), a valid press updates a latched candidate select
//    for the LED display instead of voting.

---
 rtl/vote_button_conditioner_pkg.sv | 41 ++++
 rtl/vote_button_conditioner_sync2.sv | 30 +++
 rtl/vote_button_conditioner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vote_button_conditioner_pkg.sv
// Shared definitions for the vote front end: FSM encoding, candidate count and index constants.
// The voting core imports the same package so both agree on candidate numbering.
package vote_button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_FIRE         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    localparam int NUM_CANDIDATES = 4;

    localparam logic [1:0] CAND_1 = 2'd0;
    localparam logic [1:0] CAND_2 = 2'd1;
    localparam logic [1:0] CAND_3 = 2'd2;
    localparam logic [1:0] CAND_4 = 2'd3;

    function automatic logic is_onehot(input logic [NUM_CANDIDATES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            n += int'(v[i]);
        end
        return (n == 1);
    endfunction

    // Only ever called with a one-hot code; anything else maps to candidate 1.
    function automatic logic [1:0] onehot_to_index(input logic [NUM_CANDIDATES-1:0] code);
        logic [1:0] idx;
        case (code)
            4'b0001: idx = CAND_1;
            4'b0010: idx = CAND_2;
            4'b0100: idx = CAND_3;
            4'b1000: idx = CAND_4;
            default: idx = CAND_1;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/vote_button_conditioner_sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs, synchronous reset to 0.
module vote_button_conditioner_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic r_meta;
            logic r_sync;

            always_ff @(posedge i_clk) begin
                if (i_srst) begin
                    r_meta <= 1'b0;
                    r_sync <= 1'b0;
                end else begin
                    r_meta <= i_async[gi];
                    r_sync <= r_meta;
                end
            end

            assign o_sync[gi] = r_sync;
        end
    endgenerate

endmodule

// File: rtl/vote_button_conditioner.sv
// Button front end for the voting core: synchronize, debounce, reject multi-press,
// and emit one vote strobe (or a result-mode selection) per accepted press.
module vote_button_conditioner
    import vote_button_conditioner_pkg::*;
#(
    parameter int HOLD_CYCLES    = 8,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic [3:0] vote_pulse,
    output logic       invalid_pulse,
    output logic [1:0] sel_candidate,
    output logic       sel_valid,
    output logic       busy
);

    localparam int CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam int RCNT_W = $clog2(RELEASE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RELEASE_CYCLES - 1);

    logic [NUM_CANDIDATES-1:0] w_btn_raw;
    logic [NUM_CANDIDATES-1:0] w_btn_s;
    logic                      w_zero;
    logic                      w_onehot;
    logic                      w_match;

    state_t                    r_state;
    logic [NUM_CANDIDATES-1:0] r_code;
    logic [CNT_W-1:0]          r_cnt;
    logic [RCNT_W-1:0]         r_rcnt;
    logic                      r_mode_q;
    logic                      r_mode_cap;
    logic [3:0]                r_vote;
    logic                      r_invalid;
    logic [1:0]                r_sel_cand;
    logic                      r_sel_valid;

    assign w_btn_raw = {button4, button3, button2, button1};

    vote_button_conditioner_sync2 #(
        .WIDTH (NUM_CANDIDATES)
    ) u_sync (
        .i_clk   (clock),
        .i_srst  (reset),
        .i_async (w_btn_raw),
        .o_sync  (w_btn_s)
    );

    assign w_zero   = (w_btn_s == '0);
    assign w_onehot = is_onehot(w_btn_s);
    assign w_match  = (w_btn_s == r_code);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_code      <= '0;
            r_cnt       <= '0;
            r_rcnt      <= '0;
            r_mode_q    <= 1'b0;
            r_mode_cap  <= 1'b0;
            r_vote      <= '0;
            r_invalid   <= 1'b0;
            r_sel_cand  <= '0;
            r_sel_valid <= 1'b0;
        end else begin
            r_mode_q  <= mode;
            r_vote    <= '0;
            r_invalid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_rcnt <= '0;
                    if (w_onehot) begin
                        r_code     <= w_btn_s;
                        r_mode_cap <= r_mode_q;
                        r_cnt      <= CNT_ONE;
                        r_state    <= ST_DEBOUNCE;
                    end else if (!w_zero) begin
                        r_invalid <= 1'b1;
                        r_state   <= ST_WAIT_RELEASE;
                    end
                end

                ST_DEBOUNCE: begin
                    // A mode flip mid-press makes the press ambiguous; drop it silently.
                    if (r_mode_q != r_mode_cap) begin
                        r_rcnt  <= '0;
                        r_state <= ST_WAIT_RELEASE;
                    end else if (w_match) begin
                        if (r_cnt >= CNT_LAST) begin
                            // Outputs are loaded on entry so they are visible during FIRE.
                            r_state <= ST_FIRE;
                            if (r_mode_q) begin
                                r_sel_cand  <= onehot_to_index(r_code);
                                r_sel_valid <= 1'b1;
                            end else begin
                                r_vote <= r_code;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end else if (w_zero) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_invalid <= 1'b1;
                        r_rcnt    <= '0;
                        r_state   <= ST_WAIT_RELEASE;
                    end
                end

                ST_FIRE: begin
                    r_cnt   <= '0;
                    r_rcnt  <= '0;
                    r_state <= ST_WAIT_RELEASE;
                end

                ST_WAIT_RELEASE: begin
                    if (!w_zero) begin
                        r_rcnt <= '0;
                    end else if (r_rcnt >= RCNT_LAST) begin
                        r_rcnt  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rcnt <= r_rcnt + RCNT_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vote_pulse    = r_vote;
    assign invalid_pulse = r_invalid;
    assign sel_candidate = r_sel_cand;
    assign sel_valid     = r_sel_valid;
    assign busy          = (r_state != ST_IDLE);

endmodule
